// File: rtl/uart_rx_axis.sv
// uart_rx_axis: buffers UART receiver byte pulses in a FWFT FIFO and
// presents them as an AXI4-Stream master. Parity-failed bytes carry tuser=1.
// Optional idle-gap tlast framing: define UART_AXIS_TLAST_EN.
module uart_rx_axis #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned IDLE_CYCLES = 10000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_BITS-1:0]   rx_data,
  input  logic                   rx_valid,
  input  logic                   parity_error,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IDLE_CYCLES < 2) begin : g_bad_params
    $error("uart_rx_axis: DEPTH must be a power of 2 >= 2 and IDLE_CYCLES >= 2");
  end

  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             drop_cnt_q, drop_cnt_d;
  logic [DATA_BITS:0]     mem_q [DEPTH];

  logic                   rx_event;
  logic                   full, empty, pop, can_push, push_ok, drop_ev;
  logic                   push_req, push_droppable, push_user;
  logic [DATA_BITS-1:0]   push_data;
  logic [DATA_BITS:0]     head;

  assign rx_event = rx_valid | parity_error;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign pop      = !empty && m_axis_tready;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign can_push = !full || pop;
  assign push_ok  = push_req && can_push;
  assign drop_ev  = push_req && push_droppable && !can_push;

  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : head[DATA_BITS-1:0];
  assign m_axis_tuser  = !empty && head[DATA_BITS];
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;
  assign fifo_level    = wr_ptr_q - rd_ptr_q;

`ifdef UART_AXIS_TLAST_EN
  localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

  logic                 stg_valid_q, stg_valid_d;
  logic [DATA_BITS-1:0] stg_data_q, stg_data_d;
  logic                 stg_user_q, stg_user_d;
  logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
  logic                 push_last;
  logic                 last_mem_q [DEPTH];

  // Staging: a new byte flushes the staged one (tlast=0); an idle gap flushes it with tlast=1.
  always_comb begin
    push_req       = 1'b0;
    push_droppable = 1'b0;
    push_data      = stg_data_q;
    push_user      = stg_user_q;
    push_last      = 1'b0;
    stg_valid_d    = stg_valid_q;
    stg_data_d     = stg_data_q;
    stg_user_d     = stg_user_q;
    idle_cnt_d     = idle_cnt_q;
    if (rx_event) begin
      push_req       = stg_valid_q;
      push_droppable = 1'b1;
      stg_valid_d    = 1'b1;
      stg_data_d     = rx_data;
      stg_user_d     = parity_error;
      idle_cnt_d     = '0;
    end else if (stg_valid_q) begin
      if (idle_cnt_q == IDLE_MAX) begin
        // Held and retried every cycle while the FIFO is full; never dropped.
        push_req  = 1'b1;
        push_last = 1'b1;
        if (can_push) begin
          stg_valid_d = 1'b0;
        end
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  // Staging register and idle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_valid_q <= 1'b0;
      stg_data_q  <= '0;
      stg_user_q  <= 1'b0;
      idle_cnt_q  <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_data_q  <= stg_data_d;
      stg_user_q  <= stg_user_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  // tlast storage alongside the data entries.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      last_mem_q[wr_ptr_q[AW-1:0]] <= push_last;
    end
  end

  assign m_axis_tlast = !empty && last_mem_q[rd_ptr_q[AW-1:0]];
`else
  // Bytes go straight into the FIFO.
  always_comb begin
    push_req       = rx_event;
    push_droppable = 1'b1;
    push_data      = rx_data;
    push_user      = parity_error;
  end

  assign m_axis_tlast = 1'b0;
`endif

  // Pointer and drop-accounting next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (drop_ev) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  // FIFO pointers and sticky overflow state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Entry storage {tuser, tdata}; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {push_user, push_data};
    end
  end

endmodule

// File: tb/tb_uart_rx_axis.sv
// Bench for uart_rx_axis: directed vector table, hand sequences and random
// traffic, all checked against a queue-based reference model.
module tb_uart_rx_axis;

  localparam int unsigned DB    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned IDLE  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid, parity_error, m_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser, overflow;
  logic [7:0] drop_cnt;
  logic [4:0] fifo_level;

  always #5 clk = ~clk;

  uart_rx_axis #(
    .DATA_BITS  (DB),
    .DEPTH      (DEPTH),
    .IDLE_CYCLES(IDLE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .parity_error (parity_error),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .fifo_level   (fifo_level)
  );

  typedef struct {
    logic [7:0] d;
    logic       u;
    logic       l;
  } ent_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         edge_n;
  } beat_t;

  typedef struct {
    logic       v;
    logic       p;
    logic [7:0] d;
    logic       r;
    logic       ev;
    logic [7:0] ed;
    logic       eu;
    logic [4:0] el;
  } vec_t;

  // Reference model state
  ent_t  q[$];
  bit    m_ovf;
  int    m_drop;
  bit    stg_v;
  logic [7:0] stg_d;
  logic  stg_u;
  int    stg_edge;
  int    n_edge = 0;

  int    n_cmp = 0;
  int    n_err = 0;
  bit    logging = 1'b0;
  beat_t beats[$];

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic model_step();
    ent_t e;
    bit   want, droppable, pop, acc;
    e         = '{8'h00, 1'b0, 1'b0};
    want      = 1'b0;
    droppable = 1'b0;
    n_edge++;
    if (!rst_n) begin
      q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
      stg_v  = 1'b0;
      return;
    end
    pop = (q.size() > 0) && m_axis_tready;
`ifdef UART_AXIS_TLAST_EN
    if (rx_valid || parity_error) begin
      if (stg_v) begin
        want      = 1'b1;
        droppable = 1'b1;
        e         = '{stg_d, stg_u, 1'b0};
      end
      stg_v    = 1'b1;
      stg_d    = rx_data;
      stg_u    = parity_error;
      stg_edge = n_edge;
    end else if (stg_v && (n_edge - stg_edge) >= int'(IDLE + 1)) begin
      want = 1'b1;
      e    = '{stg_d, stg_u, 1'b1};
    end
`else
    if (rx_valid || parity_error) begin
      want      = 1'b1;
      droppable = 1'b1;
      e         = '{rx_data, parity_error, 1'b0};
    end
`endif
    acc = want && ((q.size() < int'(DEPTH)) || pop);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(e);
`ifdef UART_AXIS_TLAST_EN
    if (acc && e.l) stg_v = 1'b0;
`endif
    if (want && !acc && droppable) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic check_model(input string tag);
    ent_t h;
    h = '{8'h00, 1'b0, 1'b0};
    if (q.size() > 0) h = q[0];
    cmp({tag, ".tvalid"}, 32'(m_axis_tvalid), 32'(q.size() > 0));
    cmp({tag, ".tdata"},  32'(m_axis_tdata),  32'(h.d));
    cmp({tag, ".tuser"},  32'(m_axis_tuser),  32'(h.u));
    cmp({tag, ".tlast"},  32'(m_axis_tlast),  32'(h.l));
    cmp({tag, ".level"},  32'(fifo_level),    32'(q.size()));
    cmp({tag, ".ovf"},    32'(overflow),      32'(m_ovf));
    cmp({tag, ".drop"},   32'(drop_cnt),      32'(m_drop));
  endtask

  task automatic tick(input logic v, input logic p, input logic [7:0] d, input logic r);
    rx_valid      = v;
    parity_error  = p;
    rx_data       = d;
    m_axis_tready = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model("model");
    if (logging && m_axis_tvalid) beats.push_back('{m_axis_tdata, m_axis_tlast, n_edge});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];
    int   c3;

    vt[0] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 5'd1};
    vt[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0};
    vt[2] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 5'd1};
    vt[3] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 8'h3C, 1'b1, 5'd2};
    vt[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b1, 5'd1};
    vt[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0};
    vt[6] = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0, 5'd1};
    vt[7] = '{1'b1, 1'b0, 8'h77, 1'b1, 1'b1, 8'h77, 1'b0, 5'd1};
    vt[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b0, 5'd1};
    vt[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0};

    rst_n         = 1'b0;
    rx_valid      = 1'b0;
    parity_error  = 1'b0;
    rx_data       = 8'h00;
    m_axis_tready = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 8'h00, 1'b0);
    cmp("rst.tvalid", 32'(m_axis_tvalid), 32'd0);
    cmp("rst.tdata",  32'(m_axis_tdata),  32'd0);
    cmp("rst.tuser",  32'(m_axis_tuser),  32'd0);
    cmp("rst.tlast",  32'(m_axis_tlast),  32'd0);
    cmp("rst.ovf",    32'(overflow),      32'd0);
    cmp("rst.drop",   32'(drop_cnt),      32'd0);
    cmp("rst.level",  32'(fifo_level),    32'd0);
    rst_n = 1'b1;

`ifndef UART_AXIS_TLAST_EN
    // Directed vectors: single beat, parity flag, concurrent pulses, push+pop, stall
    for (int unsigned i = 0; i < 10; i++) begin
      tick(vt[i].v, vt[i].p, vt[i].d, vt[i].r);
      cmp($sformatf("vec%0d.tvalid", i), 32'(m_axis_tvalid), 32'(vt[i].ev));
      cmp($sformatf("vec%0d.tdata", i),  32'(m_axis_tdata),  32'(vt[i].ed));
      cmp($sformatf("vec%0d.tuser", i),  32'(m_axis_tuser),  32'(vt[i].eu));
      cmp($sformatf("vec%0d.level", i),  32'(fifo_level),    32'(vt[i].el));
    end
`else
    // Idle-gap framing: tlast only on the byte before the gap
    do_reset();
    logging = 1'b1;
    tick(1'b1, 1'b0, 8'h01, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 8'h00, 1'b1);
    tick(1'b1, 1'b0, 8'h02, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 8'h00, 1'b1);
    tick(1'b1, 1'b0, 8'h03, 1'b1);
    c3 = n_edge;
    repeat (IDLE + 12) tick(1'b0, 1'b0, 8'h00, 1'b1);
    logging = 1'b0;
    cmp("gap.beats", 32'(beats.size()), 32'd3);
    if (beats.size() == 3) begin
      cmp("gap.b0.data", 32'(beats[0].d), 32'h01);
      cmp("gap.b0.last", 32'(beats[0].l), 32'd0);
      cmp("gap.b1.data", 32'(beats[1].d), 32'h02);
      cmp("gap.b1.last", 32'(beats[1].l), 32'd0);
      cmp("gap.b2.data", 32'(beats[2].d), 32'h03);
      cmp("gap.b2.last", 32'(beats[2].l), 32'd1);
      cmp("gap.b2.delay", 32'(beats[2].edge_n - c3), 32'd9);
    end
`endif

    // Overflow: DEPTH+3 pushes with the sink stalled, then drain
    do_reset();
    for (int unsigned i = 0; i < DEPTH + 3; i++) tick(1'b1, 1'b0, 8'(i), 1'b0);
`ifndef UART_AXIS_TLAST_EN
    cmp("ovf.level", 32'(fifo_level), 32'd16);
    cmp("ovf.flag",  32'(overflow),   32'd1);
    cmp("ovf.drop",  32'(drop_cnt),   32'd3);
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
`ifndef UART_AXIS_TLAST_EN
      cmp($sformatf("drain%0d.tdata", i), 32'(m_axis_tdata), i);
`endif
      tick(1'b0, 1'b0, 8'h00, 1'b1);
    end
    repeat (IDLE + 4) tick(1'b0, 1'b0, 8'h00, 1'b1);

    // Full FIFO with a push and pop on the same edge
    do_reset();
    for (int unsigned i = 0; i < DEPTH + 1; i++) tick(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    tick(1'b1, 1'b0, 8'hEE, 1'b1);
`ifndef UART_AXIS_TLAST_EN
    cmp("fullpop.level", 32'(fifo_level), 32'd16);
    cmp("fullpop.drop",  32'(drop_cnt),   32'd1);
    cmp("fullpop.tdata", 32'(m_axis_tdata), 32'h41);
`endif

    // Reset with bytes buffered (and one staged when framing is on)
    do_reset();
    tick(1'b1, 1'b0, 8'hA1, 1'b0);
    tick(1'b1, 1'b0, 8'hA2, 1'b0);
    tick(1'b1, 1'b1, 8'hA3, 1'b0);
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < IDLE + 5; i++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      cmp($sformatf("midrst%0d.tvalid", i), 32'(m_axis_tvalid), 32'd0);
    end

    // Drop counter saturation
    do_reset();
    repeat (DEPTH + 304) tick(1'b1, 1'b0, 8'($urandom), 1'b0);
    cmp("sat.drop",  32'(drop_cnt),   32'd255);
    cmp("sat.ovf",   32'(overflow),   32'd1);
    cmp("sat.level", 32'(fifo_level), 32'd16);

    // Random traffic with occasional stalls and idle gaps
    do_reset();
    for (int unsigned i = 0; i < 3000; i++) begin
      logic v, p, r;
      v = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 2) != 0);
      tick(v, p, 8'($urandom), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
